// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the ALU instruction control sequencer.
//
// Holds the sequencer state enum, the opcode encodings, the IR field bit
// positions and the registered control-word struct used by alu_ctrl_seq.
//
// Build option: ALU_CTRL_SEQ_MULDIV_EN adds the T6 state, the mul/div
// opcodes and the LO/HI/ZHigh strobes to the control word.
package cpu_pkg;

    localparam int IR_W = 32;
    localparam int NREG = 16;

    // IR field positions
    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

    // Register-register ALU class: 00011 .. 01011 inclusive
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
`ifdef ALU_CTRL_SEQ_MULDIV_EN
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
`ifdef ALU_CTRL_SEQ_MULDIV_EN
        S_T6,
`endif
        S_DONE
    } state_t;

    typedef struct packed {
        logic [4:0] op;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
    } ir_fields_t;

    // Registered control word; one flop per output strobe.
    typedef struct packed {
        logic            busy;
        logic            done;
        logic            illegal;
        logic            pc_out;
        logic            inc_pc;
        logic            mar_in;
        logic            read;
        logic            mdr_in;
        logic            mdr_out;
        logic            ir_in;
        logic            y_in;
        logic            z_in;
        logic            zlo_out;
`ifdef ALU_CTRL_SEQ_MULDIV_EN
        logic            lo_in;
        logic            hi_in;
        logic            zhi_out;
`endif
        logic [NREG-1:0] rin;
        logic [NREG-1:0] rout;
        logic [4:0]      opcode;
    } ctrl_t;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if -- handshake and strobe bundle between the sequencer and
// its datapath.
//
//   inputs to sequencer : start, mem_ready, ir[31:0]
//   outputs             : busy, done, illegal, PCout, incPC, MARin, read,
//                         MDRin, MDRout, IRin, Yin, Zin, ZLowOut,
//                         Rin[15:0], Rout[15:0], opcode[4:0]
//   ALU_CTRL_SEQ_MULDIV_EN adds outputs LOin, HIin, ZHighOut.
//
// master: the side that issues instructions (datapath / bench)
// slave : the sequencer
interface alu_ctrl_seq_if;

    logic                        start;
    logic                        mem_ready;
    logic [cpu_pkg::IR_W-1:0]    ir;

    logic                        busy;
    logic                        done;
    logic                        illegal;
    logic                        PCout;
    logic                        incPC;
    logic                        MARin;
    logic                        read;
    logic                        MDRin;
    logic                        MDRout;
    logic                        IRin;
    logic                        Yin;
    logic                        Zin;
    logic                        ZLowOut;
`ifdef ALU_CTRL_SEQ_MULDIV_EN
    logic                        LOin;
    logic                        HIin;
    logic                        ZHighOut;
`endif
    logic [cpu_pkg::NREG-1:0]    Rin;
    logic [cpu_pkg::NREG-1:0]    Rout;
    logic [4:0]                  opcode;

    modport master (
        output start, mem_ready, ir,
        input  busy, done, illegal, PCout, incPC, MARin, read, MDRin, MDRout,
               IRin, Yin, Zin, ZLowOut, Rin, Rout, opcode
`ifdef ALU_CTRL_SEQ_MULDIV_EN
             , LOin, HIin, ZHighOut
`endif
    );

    modport slave (
        input  start, mem_ready, ir,
        output busy, done, illegal, PCout, incPC, MARin, read, MDRin, MDRout,
               IRin, Yin, Zin, ZLowOut, Rin, Rout, opcode
`ifdef ALU_CTRL_SEQ_MULDIV_EN
             , LOin, HIin, ZHighOut
`endif
    );

endinterface

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec -- combinational instruction decode for alu_ctrl_seq.
//
//   f_i      : opcode / Ra / Rb / Rc fields of the instruction
//   legal_o  : opcode is one the sequencer can execute
//   muldiv_o : opcode is mul or div (ALU_CTRL_SEQ_MULDIV_EN builds only)
//   ra/rb/rc_oh_o : 4-to-16 one-hot register selects
module alu_ctrl_dec
    import cpu_pkg::*;
(
    input  ir_fields_t       f_i,
    output logic             legal_o,
`ifdef ALU_CTRL_SEQ_MULDIV_EN
    output logic             muldiv_o,
`endif
    output logic [NREG-1:0]  ra_oh_o,
    output logic [NREG-1:0]  rb_oh_o,
    output logic [NREG-1:0]  rc_oh_o
);

    function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    logic rr;

    always_comb begin
        rr = 1'b0;
        case (f_i.op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: rr = 1'b1;
            default:                         rr = 1'b0;
        endcase
    end

`ifdef ALU_CTRL_SEQ_MULDIV_EN
    assign muldiv_o = (f_i.op == OP_MUL) || (f_i.op == OP_DIV);
    assign legal_o  = rr | muldiv_o;
`else
    assign legal_o  = rr;
`endif

    assign ra_oh_o = onehot(f_i.ra);
    assign rb_oh_o = onehot(f_i.rb);
    assign rc_oh_o = onehot(f_i.rc);

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq -- Moore control sequencer for one register-register ALU
// instruction: fetch (T0-T2), operand/ALU steps (T3-T5), DONE.
//
// Ports:
//   clock : system clock, rising edge
//   clear : asynchronous active-high reset (forces IDLE, outputs to 0)
//   bus   : alu_ctrl_seq_if.slave -- start/mem_ready/ir in, strobes out
//
// Build option: ALU_CTRL_SEQ_MULDIV_EN enables mul/div (opcodes 01111,
// 10000) with a T6 step that moves the high half of Z into HI.
//
// Every output is a flop loaded from a decode of the next state, so the
// outputs line up with the present state while no input reaches an output
// without passing through a register.
module alu_ctrl_seq
    import cpu_pkg::*;
(
    input  logic          clock,
    input  logic          clear,
    alu_ctrl_seq_if.slave bus
);

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    ir_fields_t       fld_live, fld_q, fld;
    logic             legal;
    logic [NREG-1:0]  ra_oh, rb_oh, rc_oh;
`ifdef ALU_CTRL_SEQ_MULDIV_EN
    logic             muldiv;
`endif
    logic             unused_ir_bits;

    assign fld_live = '{op: bus.ir[OP_HI:OP_LO],
                        ra: bus.ir[RA_HI:RA_LO],
                        rb: bus.ir[RB_HI:RB_LO],
                        rc: bus.ir[RC_HI:RC_LO]};
    assign unused_ir_bits = ^bus.ir[RC_LO-1:0];

    // T3's strobes are loaded on the T2->T3 edge, so the decode looks at ir
    // directly while in T2 and at the copy captured on that same edge for
    // the rest of the instruction. ir must therefore hold the instruction by
    // the end of T2; later changes on ir cannot split one instruction
    // between two decodes.
    assign fld = (state_q == S_T2) ? fld_live : fld_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            fld_q <= '0;
        else if (state_q == S_T2)
            fld_q <= fld_live;
    end

    alu_ctrl_dec u_dec (
        .f_i      (fld),
        .legal_o  (legal),
`ifdef ALU_CTRL_SEQ_MULDIV_EN
        .muldiv_o (muldiv),
`endif
        .ra_oh_o  (ra_oh),
        .rb_oh_o  (rb_oh),
        .rc_oh_o  (rc_oh)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (bus.mem_ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3:   state_d = legal ? S_T4 : S_DONE;
            S_T4:   state_d = S_T5;
`ifdef ALU_CTRL_SEQ_MULDIV_EN
            S_T5:   state_d = muldiv ? S_T6 : S_DONE;
            S_T6:   state_d = S_DONE;
`else
            S_T5:   state_d = S_DONE;
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------- output decode
    always_comb begin
        ctrl_d        = '0;
        ctrl_d.opcode = ctrl_q.opcode;   // held between T4 visits
        ctrl_d.busy   = (state_d != S_IDLE);
        case (state_d)
            S_T0: begin
                ctrl_d.pc_out = 1'b1;
                ctrl_d.mar_in = 1'b1;
                ctrl_d.inc_pc = 1'b1;
            end
            S_T1: begin
                ctrl_d.read   = 1'b1;
                ctrl_d.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl_d.mdr_out = 1'b1;
                ctrl_d.ir_in   = 1'b1;
            end
            S_T3: begin
                // An unsupported opcode still spends one cycle in T3 (for
                // the decode) but drives nothing onto the bus.
                if (legal) begin
                    ctrl_d.rout = rb_oh;
                    ctrl_d.y_in = 1'b1;
                end
            end
            S_T4: begin
                ctrl_d.rout   = rc_oh;
                ctrl_d.z_in   = 1'b1;
                ctrl_d.opcode = fld.op;
            end
            S_T5: begin
                ctrl_d.zlo_out = 1'b1;
`ifdef ALU_CTRL_SEQ_MULDIV_EN
                if (muldiv)
                    ctrl_d.lo_in = 1'b1;
                else
                    ctrl_d.rin = ra_oh;
`else
                ctrl_d.rin = ra_oh;
`endif
            end
`ifdef ALU_CTRL_SEQ_MULDIV_EN
            S_T6: begin
                ctrl_d.zhi_out = 1'b1;
                ctrl_d.hi_in   = 1'b1;
            end
`endif
            S_DONE: begin
                ctrl_d.done    = 1'b1;
                // The only path T3 -> DONE is the illegal-opcode exit.
                ctrl_d.illegal = (state_q == S_T3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            ctrl_q <= '0;
        else
            ctrl_q <= ctrl_d;
    end

    assign bus.busy    = ctrl_q.busy;
    assign bus.done    = ctrl_q.done;
    assign bus.illegal = ctrl_q.illegal;
    assign bus.PCout   = ctrl_q.pc_out;
    assign bus.incPC   = ctrl_q.inc_pc;
    assign bus.MARin   = ctrl_q.mar_in;
    assign bus.read    = ctrl_q.read;
    assign bus.MDRin   = ctrl_q.mdr_in;
    assign bus.MDRout  = ctrl_q.mdr_out;
    assign bus.IRin    = ctrl_q.ir_in;
    assign bus.Yin     = ctrl_q.y_in;
    assign bus.Zin     = ctrl_q.z_in;
    assign bus.ZLowOut = ctrl_q.zlo_out;
`ifdef ALU_CTRL_SEQ_MULDIV_EN
    assign bus.LOin     = ctrl_q.lo_in;
    assign bus.HIin     = ctrl_q.hi_in;
    assign bus.ZHighOut = ctrl_q.zhi_out;
`endif
    assign bus.Rin     = ctrl_q.rin;
    assign bus.Rout    = ctrl_q.rout;
    assign bus.opcode  = ctrl_q.opcode;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq -- self-checking bench for alu_ctrl_seq.
// Table of instructions run through a scoreboard, plus hand-written
// sequences for asynchronous clear mid-instruction and start held high.
// Works with or without ALU_CTRL_SEQ_MULDIV_EN.
module tb_alu_ctrl_seq;

`ifdef ALU_CTRL_SEQ_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    alu_ctrl_seq_if bus();

    alu_ctrl_seq dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0] op;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
        int         stall;
        bit         legal;
        bit         md;
    } vec_t;

    typedef struct packed {
        int          lat;
        int          busy;
        int          t0cyc;
        int          t0cnt;
        int          reads;
        int          t2cnt;
        int          ycnt;
        logic [15:0] rout_y;
        int          zcnt;
        logic [15:0] rout_z;
        logic [4:0]  op_z;
        int          zlocnt;
        logic [15:0] rin_zlo;
        logic [15:0] rin_other;
        int          locnt;
        int          hicnt;
        int          illcnt;
        bit          ill_done;
        logic [4:0]  op_hold;
    } res_t;

    res_t       exp_q[$];
    logic [4:0] last_op = 5'b00000;

    function automatic logic [63:0] all_outs();
        logic [63:0] v;
        v = {14'h0, bus.busy, bus.done, bus.illegal, bus.PCout, bus.incPC, bus.MARin,
             bus.read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Zin, bus.ZLowOut,
             bus.Rin, bus.Rout, bus.opcode};
`ifdef ALU_CTRL_SEQ_MULDIV_EN
        v[63:61] = {bus.LOin, bus.HIin, bus.ZHighOut};
`endif
        return v;
    endfunction

    // Expected observation for one instruction, straight from the sequence
    // description: T0,T1(+stall),T2,T3,[T4,T5,(T6)],DONE.
    function automatic res_t model(input vec_t v, input logic [4:0] prev_op);
        res_t        r;
        logic [15:0] one;
        one         = 16'h0001;
        r           = '0;
        r.t0cyc     = 1;
        r.t0cnt     = 1;
        r.reads     = v.stall + 1;
        r.t2cnt     = 1;
        r.illcnt    = v.legal ? 0 : 1;
        r.ill_done  = !v.legal;
        r.op_hold   = prev_op;
        if (v.legal) begin
            r.lat     = 7 + v.stall + (v.md ? 1 : 0);
            r.ycnt    = 1;
            r.rout_y  = one << v.rb;
            r.zcnt    = 1;
            r.rout_z  = one << v.rc;
            r.op_z    = v.op;
            r.zlocnt  = 1;
            r.rin_zlo = v.md ? 16'h0 : (one << v.ra);
            r.locnt   = v.md ? 1 : 0;
            r.hicnt   = v.md ? 1 : 0;
            r.op_hold = v.op;
        end else begin
            r.lat     = 5 + v.stall;
        end
        r.busy = r.lat;
        return r;
    endfunction

    task automatic run_instr(input string tag, input vec_t v);
        res_t o, e;
        bit   got_done;
        o        = '0;
        got_done = 1'b0;
        exp_q.push_back(model(v, last_op));
        if (v.legal) last_op = v.op;
        @(negedge clock);
        bus.ir        = {v.op, v.ra, v.rb, v.rc, 15'($urandom)};
        bus.start     = 1'b1;
        bus.mem_ready = 1'b0;
        for (int c = 1; c <= 40 && !got_done; c++) begin
            @(negedge clock);
            bus.start = 1'b0;
            chk({tag, ".rin_1hot"},  64'($countones(bus.Rin)  <= 1), 64'd1);
            chk({tag, ".rout_1hot"}, 64'($countones(bus.Rout) <= 1), 64'd1);
            if (bus.busy) o.busy++;
            if (bus.PCout && bus.MARin && bus.incPC) begin
                o.t0cnt++;
                if (o.t0cyc == 0) o.t0cyc = c;
            end
            if (bus.read && bus.MDRin) o.reads++;
            // mem_ready low for the first v.stall cycles of T1
            bus.mem_ready = bus.read && (o.reads > v.stall);
            if (bus.MDRout && bus.IRin) o.t2cnt++;
            if (bus.Yin) begin o.ycnt++; o.rout_y |= bus.Rout; end
            if (bus.Zin) begin o.zcnt++; o.rout_z |= bus.Rout; o.op_z = bus.opcode; end
            if (bus.ZLowOut) begin o.zlocnt++; o.rin_zlo |= bus.Rin; end
            else o.rin_other |= bus.Rin;
`ifdef ALU_CTRL_SEQ_MULDIV_EN
            if (bus.LOin && bus.ZLowOut) o.locnt++;
            if (bus.HIin && bus.ZHighOut) o.hicnt++;
`endif
            if (bus.illegal) o.illcnt++;
            if (bus.done) begin
                o.lat      = c;
                o.ill_done = bus.illegal;
                o.op_hold  = bus.opcode;
                got_done   = 1'b1;
            end
        end
        if (!got_done) chk({tag, ".done_timeout"}, 64'd0, 64'd1);
        e = exp_q.pop_front();
        chk({tag, ".lat"},       64'(o.lat),       64'(e.lat));
        chk({tag, ".busy"},      64'(o.busy),      64'(e.busy));
        chk({tag, ".t0cyc"},     64'(o.t0cyc),     64'(e.t0cyc));
        chk({tag, ".t0cnt"},     64'(o.t0cnt),     64'(e.t0cnt));
        chk({tag, ".reads"},     64'(o.reads),     64'(e.reads));
        chk({tag, ".t2cnt"},     64'(o.t2cnt),     64'(e.t2cnt));
        chk({tag, ".ycnt"},      64'(o.ycnt),      64'(e.ycnt));
        chk({tag, ".rout_y"},    64'(o.rout_y),    64'(e.rout_y));
        chk({tag, ".zcnt"},      64'(o.zcnt),      64'(e.zcnt));
        chk({tag, ".rout_z"},    64'(o.rout_z),    64'(e.rout_z));
        chk({tag, ".op_z"},      64'(o.op_z),      64'(e.op_z));
        chk({tag, ".zlocnt"},    64'(o.zlocnt),    64'(e.zlocnt));
        chk({tag, ".rin_zlo"},   64'(o.rin_zlo),   64'(e.rin_zlo));
        chk({tag, ".rin_other"}, 64'(o.rin_other), 64'(e.rin_other));
        chk({tag, ".locnt"},     64'(o.locnt),     64'(e.locnt));
        chk({tag, ".hicnt"},     64'(o.hicnt),     64'(e.hicnt));
        chk({tag, ".illcnt"},    64'(o.illcnt),    64'(e.illcnt));
        chk({tag, ".ill_done"},  64'(o.ill_done),  64'(e.ill_done));
        chk({tag, ".op_hold"},   64'(o.op_hold),   64'(e.op_hold));
        @(negedge clock);
        chk({tag, ".idle_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, ".done_once"}, 64'(bus.done), 64'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int   t0s, dones, viol;
        bit   prev_busy;
        vec_t rol;

        vecs[0] = '{5'b01000, 4'd4,  4'd3,  4'd7,  0, 1'b1, 1'b0}; // ROL, worked example
        vecs[1] = '{5'b01000, 4'd4,  4'd3,  4'd7,  3, 1'b1, 1'b0}; // memory stall 3
        vecs[2] = '{5'b11111, 4'd1,  4'd2,  4'd3,  0, 1'b0, 1'b0}; // unsupported
        vecs[3] = '{5'b00011, 4'd5,  4'd5,  4'd5,  0, 1'b1, 1'b0}; // low edge, Ra=Rb=Rc
        vecs[4] = '{5'b01011, 4'd15, 4'd0,  4'd1,  1, 1'b1, 1'b0}; // high edge
        vecs[5] = '{5'b00010, 4'd2,  4'd9,  4'd8,  0, 1'b0, 1'b0}; // just below class
        vecs[6] = '{5'b01100, 4'd6,  4'd10, 4'd11, 2, 1'b0, 1'b0}; // just above class
        vecs[7] = '{5'b01111, 4'd12, 4'd13, 4'd14, 0, MD,   1'b1}; // mul
        vecs[8] = '{5'b10000, 4'd0,  4'd15, 4'd2,  1, MD,   1'b1}; // div
        vecs[9] = '{5'b00000, 4'd3,  4'd3,  4'd3,  0, 1'b0, 1'b0}; // opcode 0
        rol = vecs[0];

        // reset: outputs zero asynchronously, before any clock edge
        clear         = 1'b1;
        bus.start     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.ir        = '0;
        #1;
        chk("rst_async_outs", all_outs(), 64'd0);
        @(negedge clock);
        bus.start = 1'b1;               // ignored while clear is high
        @(negedge clock);
        chk("rst_hold_outs", all_outs(), 64'd0);
        bus.start = 1'b0;
        clear     = 1'b0;

        for (int i = 0; i < 10; i++)
            run_instr($sformatf("v%0d", i), vecs[i]);

        // clear during T4: immediate return to all-zero, then a clean run
        @(negedge clock);
        bus.ir        = {rol.op, rol.ra, rol.rb, rol.rc, 15'h0};
        bus.start     = 1'b1;
        bus.mem_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (bus.Zin) break;
        end
        chk("clr_reach_T4", 64'(bus.Zin), 64'd1);
        #2 clear = 1'b1;
        #1;
        chk("clr_async_outs", all_outs(), 64'd0);
        chk("clr_busy", 64'(bus.busy), 64'd0);
        chk("clr_rin", 64'(bus.Rin), 64'd0);
        last_op = 5'b00000;
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        chk("clr_idle_outs", all_outs(), 64'd0);
        run_instr("after_clr", rol);

        // start held high: one T0 per pass through IDLE
        @(negedge clock);
        bus.ir        = {rol.op, rol.ra, rol.rb, rol.rc, 15'h0};
        bus.start     = 1'b1;
        bus.mem_ready = 1'b1;
        t0s = 0; dones = 0; viol = 0; prev_busy = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clock);
            if (bus.PCout) begin
                t0s++;
                if (prev_busy) viol++;
            end
            if (bus.done) dones++;
            prev_busy = bus.busy;
        end
        bus.start = 1'b0;
        chk("hold_t0_count", 64'(t0s), 64'd2);
        chk("hold_done_count", 64'(dones), 64'd2);
        chk("hold_t0_from_busy", 64'(viol), 64'd0);
        @(negedge clock);
        chk("hold_release_idle", 64'(bus.busy), 64'd0);
        chk("hold_opcode", 64'(bus.opcode), 64'(rol.op));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
